// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: special instruction words,
// decode field positions and FSM state encodings.
package if_stage_pkg;

   localparam int unsigned NB_INSTR_DEF = 32;
   localparam int unsigned NB_PC_DEF    = 32;

   localparam logic [NB_INSTR_DEF-1:0] NOP_WORD  = 32'h0000_0000;
   localparam logic [NB_INSTR_DEF-1:0] HALT_WORD = 32'hFFFF_FFFF;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned FUNC_MSB   = 5;
   localparam int unsigned FUNC_LSB   = 0;

   // Halt flag doubles as the fetch state.
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   function automatic logic [5:0] get_opcode(input logic [NB_INSTR_DEF-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [5:0] get_func(input logic [NB_INSTR_DEF-1:0] instr);
      return instr[FUNC_MSB:FUNC_LSB];
   endfunction

endpackage

// File: rtl/if_stage_instruction_memory.sv
// Program memory: one combinational read port, one synchronous write port
// used by the debug unit for program load.
module instruction_memory #(
   parameter int unsigned N_WORDS  = 256,
   parameter int unsigned NB_INSTR = 32,
   parameter int unsigned NB_ADDR  = $clog2(N_WORDS)
) (
   input  logic                i_clock,
   input  logic                i_wr_en,
   input  logic [NB_ADDR-1:0]  i_wr_addr,
   input  logic [NB_INSTR-1:0] i_wr_data,
   input  logic [NB_ADDR-1:0]  i_rd_addr,
   output logic [NB_INSTR-1:0] o_rd_data
);

   logic [NB_INSTR-1:0] mem_q [N_WORDS];

   // Contents survive reset so a loaded program can be re-run.
   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, program memory, redirect/stall handling,
// IF/ID pipeline register and sticky HALT detection.
module if_stage
   import if_stage_pkg::*;
#(
   parameter  int unsigned NB_PC        = 32,
   parameter  int unsigned NB_INSTR     = 32,
   parameter  int unsigned N_WORDS      = 256,
   localparam int unsigned NB_IMEM_ADDR = $clog2(N_WORDS)
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_stall,
   input  logic                    i_branch_taken,
   input  logic [NB_PC-1:0]        i_branch_addr,
   input  logic                    i_jump,
   input  logic [NB_PC-1:0]        i_jump_addr,
   input  logic                    i_imem_wr_en,
   input  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr,
   input  logic [NB_INSTR-1:0]     i_imem_wr_data,
   output logic [NB_INSTR-1:0]     o_instr,
   output logic [NB_PC-1:0]        o_pc_next,
   output logic                    o_valid,
   output logic                    o_halt,
   output logic [NB_PC-1:0]        o_pc
);

   localparam logic [NB_INSTR-1:0] NOP  = NB_INSTR'(NOP_WORD);
   localparam logic [NB_INSTR-1:0] HALT = NB_INSTR'(HALT_WORD);

   logic [NB_PC-1:0]    pc_q, pc_d;
   logic [NB_INSTR-1:0] instr_q, instr_d;
   logic [NB_PC-1:0]    pc_next_q, pc_next_d;
   logic                valid_q, valid_d;
   logic [0:0]          state_q, state_d;

   logic [NB_INSTR-1:0] fetch_word;
   logic [NB_PC-1:0]    pc_plus4;

   instruction_memory #(
      .N_WORDS  (N_WORDS),
      .NB_INSTR (NB_INSTR),
      .NB_ADDR  (NB_IMEM_ADDR)
   ) u_imem (
      .i_clock   (i_clock),
      .i_wr_en   (i_imem_wr_en),
      .i_wr_addr (i_imem_wr_addr),
      .i_wr_data (i_imem_wr_data),
      .i_rd_addr (pc_q[NB_IMEM_ADDR+1:2]),
      .o_rd_data (fetch_word)
   );

   assign pc_plus4 = pc_q + NB_PC'(4);

   // Next-state selection; earlier branches of the chain take priority.
   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      pc_next_d = pc_next_q;
      valid_d   = valid_q;
      state_d   = state_q;
      if (i_enable) begin
         if (state_q == ST_HALTED) begin
            instr_d = NOP;
            valid_d = 1'b0;
         end else if (!i_stall) begin
            if (i_branch_taken) begin
               pc_d    = i_branch_addr;
               instr_d = NOP;
               valid_d = 1'b0;
            end else if (i_jump) begin
               pc_d    = i_jump_addr;
               instr_d = NOP;
               valid_d = 1'b0;
            end else if (fetch_word == HALT) begin
               instr_d   = HALT;
               pc_next_d = pc_plus4;
               valid_d   = 1'b1;
               state_d   = ST_HALTED;
            end else begin
               pc_d      = pc_plus4;
               instr_d   = fetch_word;
               pc_next_d = pc_plus4;
               valid_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         pc_q      <= '0;
         instr_q   <= NOP;
         pc_next_q <= '0;
         valid_q   <= 1'b0;
         state_q   <= ST_RUN;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc_next_q <= pc_next_d;
         valid_q   <= valid_d;
         state_q   <= state_d;
      end
   end

   assign o_instr   = instr_q;
   assign o_pc_next = pc_next_q;
   assign o_valid   = valid_q;
   assign o_halt    = (state_q == ST_HALTED);
   assign o_pc      = pc_q;

endmodule
